// File: rtl/dual_octal_demux_reg_pkg.sv
// Shared constants for the dual octal demultiplexing register.
// Target-select encoding used by both manual and ping-pong modes.
package dual_octal_demux_reg_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/dual_octal_demux_reg_oct_dreg_en.sv
// WIDTH-bit D register with async clear and synchronous enable.
// An unknown enable merges held and new data, leaving differing bits X.
module oct_dreg_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else begin
            q <= en ? d : q;
        end
    end

endmodule

// File: rtl/dual_octal_demux_reg.sv
// One input bus demultiplexed into registers A and B, with pair-ready
// tracking and open-collector or totem-pole output drivers.
module dual_octal_demux_reg
    import dual_octal_demux_reg_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter bit OPEN_COLLECTOR = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             ld_n,
    input  logic             ab,
    input  logic             auto,
    input  logic             ack_n,
    input  logic             oe_a_n,
    input  logic             oe_b_n,
    output tri logic [WIDTH-1:0] qa,
    output tri logic [WIDTH-1:0] qb,
    output logic             rdy,
    output logic             sel
);

    logic             sel_q;
    logic             va;
    logic             vb;
    logic             load;
    logic             tgt;
    logic             en_a;
    logic             en_b;
    logic [WIDTH-1:0] rega;
    logic [WIDTH-1:0] regb;

    assign load = ~ld_n;
    assign tgt  = auto ? sel_q : ab;
    assign en_a = load & (tgt == SEL_A);
    assign en_b = load & (tgt == SEL_B);

    oct_dreg_en #(.WIDTH(WIDTH)) u_rega (
        .clk (clk),
        .clr (clr),
        .en  (en_a),
        .d   (d),
        .q   (rega)
    );

    oct_dreg_en #(.WIDTH(WIDTH)) u_regb (
        .clk (clk),
        .clr (clr),
        .en  (en_b),
        .d   (d),
        .q   (regb)
    );

    // Ack clears both halves before the same-edge load re-marks its target.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_q <= SEL_A;
            va    <= 1'b0;
            vb    <= 1'b0;
        end else begin
            sel_q <= (load & auto) ? ~sel_q : sel_q;
            va    <= (va & ack_n) | en_a;
            vb    <= (vb & ack_n) | en_b;
        end
    end

    assign rdy = va & vb;
    assign sel = sel_q;

    if (OPEN_COLLECTOR) begin : g_oc
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign qa[i] = oe_a_n ? 1'bz : (rega[i] ? 1'bz : 1'b0);
            assign qb[i] = oe_b_n ? 1'bz : (regb[i] ? 1'bz : 1'b0);
        end
    end else begin : g_tp
        assign qa = oe_a_n ? {WIDTH{1'bz}} : rega;
        assign qb = oe_b_n ? {WIDTH{1'bz}} : regb;
    end

endmodule
